dmem_arbiter: RTL and testbench

- Two-requester arbiter in front of the byte-banked data memory wrapper.
- Shares the memory's single access port between the CPU MEM stage and an accelerator/DMA master (board/ship-state updater).
- CPU has fixed priority; a starvation counter guarantees the accelerator a slot.
- Tracks the 1-cycle synchronous read latency and routes each read response to the requester that issued it.

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory's single access port between the CPU
// MEM stage and the accelerator. The CPU has fixed priority, but a streak
// counter forces an accelerator grant after MAX_STREAK consecutive CPU grants
// while the accelerator waits. Read responses (1-cycle latency) are steered
// back to whichever requester issued the load.
module dmem_arbiter #(
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU request bundle
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_unsigned,
    input  logic [1:0]        cpu_width,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    // Accelerator request bundle
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic              acc_unsigned,
    input  logic [1:0]        acc_width,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [31:0]       acc_wdata,
    output logic              acc_gnt,
    output logic              acc_rvalid,
    output logic [31:0]       acc_rdata,
    output logic              acc_err,
    // Memory port
    output logic              mem_wrt_en,
    output logic              mem_rd_en,
    output logic              mem_unsigned,
    output logic [1:0]        mem_width,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wrt_data,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_error
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    // CPU_PRI: CPU wins contention; ACC_TURN: accelerator is owed a slot.
    typedef enum logic {
        CPU_PRI,
        ACC_TURN
    } pri_state_t;

    logic [3:0] streak_q, streak_d;
    pri_state_t pri_state;
    logic       acc_win, cpu_win;
    logic       bad;
    logic       rd_pend_q, rd_owner_q;

    assign pri_state = (streak_q == STREAK_MAX) ? ACC_TURN : CPU_PRI;

    // Streak register: the only arbitration state.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) streak_q <= '0;
        else        streak_q <= streak_d;
    end

    // Grant decision and next streak value.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        acc_win  = 1'b0;
        cpu_win  = 1'b0;
        streak_d = streak_q;
        if (acc_req && (!cpu_req || pri_state == ACC_TURN)) acc_win = 1'b1;
        else if (cpu_req)                                   cpu_win = 1'b1;

        if (!acc_req || acc_win)                    streak_d = '0;
        else if (cpu_win && streak_q < STREAK_MAX)  streak_d = streak_q + 4'd1;
    end

    // Memory port mux: drive the winner's bundle, all zeros when idle.
    always_comb begin
        mem_wrt_en   = 1'b0;
        mem_rd_en    = 1'b0;
        mem_unsigned = 1'b0;
        mem_width    = 2'b00;
        mem_addr     = '0;
        mem_wrt_data = '0;
        bad          = 1'b0;
        if (acc_win) begin
            bad          = mem_error || (acc_width == 2'b11);
            mem_wrt_en   = acc_we && !bad;
            mem_rd_en    = !acc_we && !bad;
            mem_unsigned = acc_unsigned;
            mem_width    = acc_width;
            mem_addr     = acc_addr;
            mem_wrt_data = acc_wdata;
        end else if (cpu_win) begin
            bad          = mem_error || (cpu_width == 2'b11);
            mem_wrt_en   = cpu_we && !bad;
            mem_rd_en    = !cpu_we && !bad;
            mem_unsigned = cpu_unsigned;
            mem_width    = cpu_width;
            mem_addr     = cpu_addr;
            mem_wrt_data = cpu_wdata;
        end
    end

    assign cpu_stall = cpu_req && !cpu_win;
    assign acc_gnt   = acc_win;
    // Errored accesses are consumed: granted, but no memory enable.
    assign cpu_err   = cpu_win && bad;
    assign acc_err   = acc_win && bad;

    // Remember which requester owns the read data returning next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q <= mem_rd_en;
            if (mem_rd_en) rd_owner_q <= acc_win;
        end
    end

    assign cpu_rvalid = rd_pend_q && !rd_owner_q;
    assign acc_rvalid = rd_pend_q && rd_owner_q;
    assign cpu_rdata  = cpu_rvalid ? mem_rd_data : 32'h0;
    assign acc_rdata  = acc_rvalid ? mem_rd_data : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vectors; read responses are checked by
// a scoreboard monitor that pops expected data whenever an rvalid appears.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_unsigned;
    logic [1:0]  cpu_width;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid, cpu_err;
    logic [31:0] cpu_rdata;
    logic        acc_req, acc_we, acc_unsigned;
    logic [1:0]  acc_width;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_gnt, acc_rvalid, acc_err;
    logic [31:0] acc_rdata;
    logic        mem_wrt_en, mem_rd_en, mem_unsigned;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr, mem_wrt_data;
    logic [31:0] mem_rd_data;
    logic        mem_error;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] cpu_q[$];
    logic [31:0] acc_q[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_STREAK(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_unsigned(cpu_unsigned),
        .cpu_width(cpu_width), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err),
        .acc_req(acc_req), .acc_we(acc_we), .acc_unsigned(acc_unsigned),
        .acc_width(acc_width), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
        .acc_err(acc_err),
        .mem_wrt_en(mem_wrt_en), .mem_rd_en(mem_rd_en), .mem_unsigned(mem_unsigned),
        .mem_width(mem_width), .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data),
        .mem_rd_data(mem_rd_data), .mem_error(mem_error)
    );

    // Memory model: misalignment flag is combinational, read data 1 cycle later.
    assign mem_error = (mem_width == 2'b10 && mem_addr[0]) ||
                       (mem_width == 2'b00 && mem_addr[1:0] != 2'b00);

    function automatic logic [31:0] mem_img(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEAD_BEEF;
            32'h20:  return 32'h0000_0011;
            32'h24:  return 32'h0000_0022;
            default: return 32'h5A5A_0000 | a;
        endcase
    endfunction

    // Garbage on idle cycles so leaked rdata on a non-owner is visible.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_img(mem_addr);
        else           mem_rd_data <= 32'hBAD0_BAD0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_grant(input string name, input logic exp_acc, input logic [31:0] exp_addr);
        check({name, "_acc_gnt"}, 32'(acc_gnt), 32'(exp_acc));
        check({name, "_cpu_stall"}, 32'(cpu_stall), 32'(exp_acc));
        check({name, "_mem_addr"}, mem_addr, exp_addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare each response against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cpu_rvalid) begin
                    if (cpu_q.size() == 0) check("cpu_unexpected_rvalid", 32'(cpu_rvalid), 32'd0);
                    else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
                end else begin
                    check("cpu_rdata_idle", cpu_rdata, 32'h0);
                end
                if (acc_rvalid) begin
                    if (acc_q.size() == 0) check("acc_unexpected_rvalid", 32'(acc_rvalid), 32'd0);
                    else check("acc_rdata", acc_rdata, acc_q.pop_front());
                end else begin
                    check("acc_rdata_idle", acc_rdata, 32'h0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_unsigned = 0; cpu_width = 2'b00; cpu_addr = 0; cpu_wdata = 0;
        acc_req = 0; acc_we = 0; acc_unsigned = 0; acc_width = 2'b00; acc_addr = 0; acc_wdata = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state with no requests.
        @(negedge clk);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_acc_rvalid", 32'(acc_rvalid), 32'd0);
        check("rst_mem_en", {30'd0, mem_rd_en, mem_wrt_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        step();

        // CPU load word from 0x10.
        cpu_req = 1; cpu_we = 0; cpu_width = 2'b00; cpu_addr = 32'h10;
        cpu_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        check("ld_mem_rd_en", 32'(mem_rd_en), 32'd1);
        check("ld_cpu_stall", 32'(cpu_stall), 32'd0);
        check("ld_mem_addr", mem_addr, 32'h10);
        step();
        cpu_req = 0;
        @(negedge clk);
        check("ld_rvalid_cycle", 32'(cpu_rvalid), 32'd1);
        step();

        // Continuous contention with stores: CPU x4 then ACC, repeating.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'h0000_C0C0;
        acc_req = 1; acc_we = 1; acc_addr = 32'h200; acc_wdata = 32'h0000_ACAC; acc_width = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_grant("streak", (i % 5) == 4, (i % 5) == 4 ? 32'h200 : 32'h100);
            check("streak_wdata", mem_wrt_data, (i % 5) == 4 ? 32'h0000_ACAC : 32'h0000_C0C0);
            check("streak_wrt_en", 32'(mem_wrt_en), 32'd1);
            step();
        end
        cpu_req = 0; acc_req = 0;
        step();

        // Alternating owners: CPU load at N, acc load at N+1.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        cpu_q.push_back(32'h11);
        @(negedge clk);
        check("alt_cpu_rd_en", 32'(mem_rd_en), 32'd1);
        step();
        cpu_req = 0;
        acc_req = 1; acc_we = 0; acc_addr = 32'h24;
        acc_q.push_back(32'h22);
        @(negedge clk);
        check("alt_acc_gnt", 32'(acc_gnt), 32'd1);
        check("alt_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        step();
        acc_req = 0;
        @(negedge clk);
        check("alt_acc_rvalid", 32'(acc_rvalid), 32'd1);
        check("alt_no_cross", 32'(cpu_rvalid), 32'd0);
        step();

        // Misaligned CPU half store, then acc load with illegal width.
        cpu_req = 1; cpu_we = 1; cpu_width = 2'b10; cpu_addr = 32'h3;
        @(negedge clk);
        check("herr_cpu_err", 32'(cpu_err), 32'd1);
        check("herr_wrt_en", 32'(mem_wrt_en), 32'd0);
        check("herr_cpu_stall", 32'(cpu_stall), 32'd0);
        step();
        cpu_req = 0; cpu_width = 2'b00;
        acc_req = 1; acc_we = 0; acc_width = 2'b11; acc_addr = 32'h8;
        @(negedge clk);
        check("werr_acc_err", 32'(acc_err), 32'd1);
        check("werr_acc_gnt", 32'(acc_gnt), 32'd1);
        check("werr_rd_en", 32'(mem_rd_en), 32'd0);
        check("werr_cpu_err", 32'(cpu_err), 32'd0);
        step();
        acc_req = 0; acc_width = 2'b00;
        @(negedge clk);
        check("werr_err_one_cycle", 32'(acc_err), 32'd0);
        step();

        // Acc load granted, reset before its response cycle.
        acc_req = 1; acc_we = 0; acc_addr = 32'h24;
        @(negedge clk);
        check("rstmid_acc_gnt", 32'(acc_gnt), 32'd1);
        check("rstmid_rd_en", 32'(mem_rd_en), 32'd1);
        #1 rst_n = 1'b0;
        acc_req = 0;
        step();
        check("rstmid_in_reset", 32'(acc_rvalid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_acc_rvalid", 32'(acc_rvalid), 32'd0);
        check("rstmid_acc_rdata", acc_rdata, 32'h0);
        check("rstmid_cpu_rdata", cpu_rdata, 32'h0);
        step();
        // Streak restarted from zero: four CPU grants before the acc.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100;
        acc_req = 1; acc_we = 1; acc_addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_grant("rststreak", i == 4, i == 4 ? 32'h200 : 32'h100);
            step();
        end

        // acc_req drops at streak 3; reassertion restarts the count.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_grant("drop_pre", 1'b0, 32'h100);
            step();
        end
        acc_req = 0;
        @(negedge clk);
        chk_grant("drop_gap", 1'b0, 32'h100);
        step();
        acc_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_grant("drop_post", i == 4, i == 4 ? 32'h200 : 32'h100);
            step();
        end
        cpu_req = 0; acc_req = 0;
        repeat (2) step();

        check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        check("acc_q_drained", 32'(acc_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
